// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Deserialises the asynchronous serial line into
// bytes and presents each good byte with a single-cycle valid pulse.
//
// Ports:
//   i_clk        UART-domain clock
//   i_rst_n      asynchronous active-low reset
//   i_rx         raw serial line (idles high), asynchronous to i_clk
//   o_data       last good byte, held until the next good frame
//   o_valid      one-cycle pulse when o_data is updated
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_nx;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    shift, shift_nx, data_nx;
  logic          valid_nx, ferr_nx;

  // Synchroniser flops reset high so the idle line never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= 2'b11;
    else          sync <= {sync[0], i_rx};
  end
  assign rx_s = sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shift       <= shift_nx;
      o_data      <= data_nx;
      o_valid     <= valid_nx;
      o_frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    data_nx  = o_data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = START;
      end
      // Re-check the line at mid start bit; a high sample means a glitch.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      // Counting a full bit from mid start bit lands every sample at mid-bit.
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nx        = '0;
          shift_nx[idx] = rx_s;
          idx_nx        = idx + 1'b1;
          if (idx == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      // Leave at mid stop bit so a start edge straight after it is not missed.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx  = shift;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = BREAK;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      // A line held low after a bad stop bit must not re-trigger frames.
      BREAK: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  // i_rx start edge to observed pulse: 2 sync cycles + mid-stop sample + register
  localparam int LAT   = 2 + HALF + 9 * CPB + 1;
  localparam int CPB_D = 868;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // monitor state
  int         vcyc_a[$];
  logic [7:0] vdat_a[$];
  int         fcyc_a[$];
  logic [7:0] vdat_b[$];
  int         ferr_b_n = 0;
  int         overlap_n = 0;
  int         unstable_n = 0;
  int         busy_rise_a = -1, busy_fall_a = -1;
  logic [7:0] prev_data_a = 8'h00;
  logic       prev_busy_a = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a),
    .o_data(data_a), .o_valid(valid_a), .o_frame_err(ferr_a), .o_busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_D)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b),
    .o_data(data_b), .o_valid(valid_b), .o_frame_err(ferr_b), .o_busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) begin
      vcyc_a.push_back(cyc);
      vdat_a.push_back(data_a);
    end
    if (ferr_a) fcyc_a.push_back(cyc);
    if (valid_b) vdat_b.push_back(data_b);
    if (ferr_b) ferr_b_n <= ferr_b_n + 1;
    if ((valid_a && ferr_a) || (valid_b && ferr_b)) overlap_n <= overlap_n + 1;
    if (rst_n && (data_a !== prev_data_a) && !valid_a) unstable_n <= unstable_n + 1;
    prev_data_a <= data_a;
    if (busy_a && !prev_busy_a) busy_rise_a <= cyc;
    if (!busy_a && prev_busy_a) busy_fall_a <= cyc;
    prev_busy_a <= busy_a;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic clear_mon();
    vcyc_a.delete();
    vdat_a.delete();
    fcyc_a.delete();
    vdat_b.delete();
    ferr_b_n = 0;
  endtask

  // Sends start, 8 data bits LSB first, then stop; t0 = cycle of the start edge.
  task automatic send_frame(input bit sel, input logic [7:0] b, input int bitlen,
                            input logic stop, output int t0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      drive(sel, bits[i]);
      tick(bitlen);
    end
  endtask

  // Expects exactly one good frame on dut_a since the last clear.
  task automatic expect_one(input string name, input int t0, input logic [7:0] b);
    checks++;
    if (vcyc_a.size() !== 1 || fcyc_a.size() !== 0) begin
      errors++;
      $display("FAIL %s_count: valid=%0d ferr=%0d, required valid=1 ferr=0",
               name, vcyc_a.size(), fcyc_a.size());
    end else begin
      checks++;
      if (vdat_a[0] !== b) begin
        errors++;
        $display("FAIL %s_data: got %02h, required %02h", name, vdat_a[0], b);
      end
      checks++;
      if (vcyc_a[0] !== t0 + LAT) begin
        errors++;
        $display("FAIL %s_cycle: got %0d, required %0d", name, vcyc_a[0], t0 + LAT);
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (data_a !== 8'h00 || valid_a !== 1'b0 || ferr_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: data=%02h v=%b fe=%b busy=%b, required all 0",
               data_a, valid_a, ferr_a, busy_a);
    end
    checks++;
    if (data_b !== 8'h00 || valid_b !== 1'b0 || ferr_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: data=%02h v=%b fe=%b busy=%b, required all 0",
               data_b, valid_b, ferr_b, busy_b);
    end
    @(negedge clk) rst_n = 1'b1;
    tick(5);
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b v=%b data=%02h, required 0", busy_a, valid_a, data_a);
    end
  endtask

  task automatic test_single();
    int t0;
    clear_mon();
    send_frame(0, 8'hA5, CPB, 1'b1, t0);
    tick(5);
    expect_one("single", t0, 8'hA5);
    checks++;
    if (busy_rise_a !== t0 + 3) begin
      errors++;
      $display("FAIL busy_rise: got %0d, required %0d", busy_rise_a, t0 + 3);
    end
    checks++;
    if (busy_fall_a !== t0 + LAT) begin
      errors++;
      $display("FAIL busy_fall: got %0d, required %0d", busy_fall_a, t0 + LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[3];
    int t0[3];
    b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'h3C;
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(0, b[i], CPB, 1'b1, t0[i]);
    tick(5);
    checks++;
    if (vcyc_a.size() !== 3 || fcyc_a.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: valid=%0d ferr=%0d, required 3/0", vcyc_a.size(), fcyc_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vdat_a[i] !== b[i] || vcyc_a[i] !== t0[0] + LAT + 160 * i) begin
          errors++;
          $display("FAIL b2b_frame%0d: data=%02h cyc=%0d, required %02h at %0d",
                   i, vdat_a[i], vcyc_a[i], b[i], t0[0] + LAT + 160 * i);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int t0;
    bit idle;
    clear_mon();
    drive(0, 1'b0);
    tick(5);
    drive(0, 1'b1);
    idle = 1'b0;
    for (int i = 0; i < 10 && !idle; i++) begin
      tick(1);
      idle = !busy_a;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL glitch_busy: busy=%b after 10 cycles, required 0", busy_a);
    end
    tick(10);
    checks++;
    if (vcyc_a.size() !== 0 || fcyc_a.size() !== 0) begin
      errors++;
      $display("FAIL glitch_pulse: valid=%0d ferr=%0d, required 0/0", vcyc_a.size(), fcyc_a.size());
    end
    clear_mon();
    send_frame(0, 8'h5A, CPB, 1'b1, t0);
    tick(5);
    expect_one("after_glitch", t0, 8'h5A);
  endtask

  task automatic test_frame_err();
    int t0;
    clear_mon();
    send_frame(0, 8'h81, CPB, 1'b0, t0);
    tick(400);
    checks++;
    if (fcyc_a.size() !== 1 || vcyc_a.size() !== 0) begin
      errors++;
      $display("FAIL ferr_count: ferr=%0d valid=%0d, required 1/0", fcyc_a.size(), vcyc_a.size());
    end else begin
      checks++;
      if (fcyc_a[0] !== t0 + LAT) begin
        errors++;
        $display("FAIL ferr_cycle: got %0d, required %0d", fcyc_a[0], t0 + LAT);
      end
    end
    checks++;
    if (data_a !== 8'h5A || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL ferr_hold: data=%02h busy=%b, required 5a/1", data_a, busy_a);
    end
    drive(0, 1'b1);
    tick(5);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL break_exit: busy=%b, required 0", busy_a);
    end
    clear_mon();
    send_frame(0, 8'h42, CPB, 1'b1, t0);
    tick(5);
    expect_one("after_break", t0, 8'h42);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int t0;
    b = 8'hC3;
    clear_mon();
    drive(0, 1'b0);
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      drive(0, b[i]);
      tick(CPB);
    end
    drive(0, b[4]);
    tick(HALF);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_a !== 8'h00 || valid_a !== 1'b0 || ferr_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: data=%02h v=%b fe=%b busy=%b, required all 0",
               data_a, valid_a, ferr_a, busy_a);
    end
    drive(0, 1'b1);
    tick(3);
    @(negedge clk) rst_n = 1'b1;
    tick(30);
    checks++;
    if (vcyc_a.size() !== 0 || fcyc_a.size() !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: valid=%0d ferr=%0d busy=%b, required 0/0/0",
               vcyc_a.size(), fcyc_a.size(), busy_a);
    end
    clear_mon();
    send_frame(0, b, CPB, 1'b1, t0);
    tick(5);
    expect_one("after_reset", t0, b);
  endtask

  // Random bytes, stop bits and idle gaps; the model predicts each frame's
  // outcome and pulse cycle from the frame rules alone.
  task automatic test_random();
    int         exp_vc[$], exp_fc[$];
    logic [7:0] exp_vd[$];
    logic [7:0] b, last_good;
    logic       stop;
    int         gap, t0;
    clear_mon();
    last_good = 8'hC3;
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 12);
      send_frame(0, b, CPB, stop, t0);
      if (stop) begin
        exp_vc.push_back(t0 + LAT);
        exp_vd.push_back(b);
        last_good = b;
        tick(gap);
      end else begin
        exp_fc.push_back(t0 + LAT);
        drive(0, 1'b1);
        tick(gap + 3);
      end
    end
    tick(5);
    checks++;
    if (vcyc_a.size() !== exp_vc.size() || fcyc_a.size() !== exp_fc.size()) begin
      errors++;
      $display("FAIL rand_count: valid=%0d ferr=%0d, required %0d/%0d",
               vcyc_a.size(), fcyc_a.size(), exp_vc.size(), exp_fc.size());
    end else begin
      for (int i = 0; i < exp_vc.size(); i++) begin
        checks++;
        if (vcyc_a[i] !== exp_vc[i] || vdat_a[i] !== exp_vd[i]) begin
          errors++;
          $display("FAIL rand_valid%0d: data=%02h cyc=%0d, required %02h at %0d",
                   i, vdat_a[i], vcyc_a[i], exp_vd[i], exp_vc[i]);
        end
      end
      for (int i = 0; i < exp_fc.size(); i++) begin
        checks++;
        if (fcyc_a[i] !== exp_fc[i]) begin
          errors++;
          $display("FAIL rand_ferr%0d: cyc=%0d, required %0d", i, fcyc_a[i], exp_fc[i]);
        end
      end
    end
    checks++;
    if (data_a !== last_good) begin
      errors++;
      $display("FAIL rand_last_data: got %02h, required %02h", data_a, last_good);
    end
  endtask

  task automatic test_skew();
    int t0;
    clear_mon();
    send_frame(1, 8'h55, 842, 1'b1, t0);
    tick(100);
    send_frame(1, 8'hAA, 894, 1'b1, t0);
    tick(500);
    checks++;
    if (vdat_b.size() !== 2 || ferr_b_n !== 0) begin
      errors++;
      $display("FAIL skew_count: valid=%0d ferr=%0d, required 2/0", vdat_b.size(), ferr_b_n);
    end else begin
      checks++;
      if (vdat_b[0] !== 8'h55 || vdat_b[1] !== 8'hAA) begin
        errors++;
        $display("FAIL skew_data: got %02h %02h, required 55 aa", vdat_b[0], vdat_b[1]);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_n !== 0) begin
      errors++;
      $display("FAIL overlap: %0d cycles with valid and frame_err together, required 0", overlap_n);
    end
    checks++;
    if (unstable_n !== 0) begin
      errors++;
      $display("FAIL data_stability: %0d changes without valid, required 0", unstable_n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_skew();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises the asynchronous serial line into bytes and presents each byte as a single-cycle valid pulse. It sits directly upstream of the UART-to-BRAM FIFO: `o_data`/`o_valid` connect to the FIFO's `i_data_uart`/`i_valid_uart` and run in the 100 MHz UART write-clock domain. Frame format is fixed at 8N1: one start bit, 8 data bits LSB first, no parity, one stop bit.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud). Legal range is 4 or more.
- `i_clk`  input  1  UART-domain clock, 100 MHz.
- `i_rst_n`  input  1  reset. One clock; reset is asynchronous and active-low.
- `i_rx`  input  1  raw serial line, asynchronous to `i_clk`. The line idles high.
- `o_data`  output  8  last received byte. Held stable until the next valid frame.
- `o_valid`  output  1  one-cycle pulse when `o_data` is updated with a good frame.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `o_busy`  output  1  high in every state except IDLE.

## Operation
- **Input synchroniser**
  - `i_rx` passes through a 2-flop synchroniser; the result is `rx_s`.
  - Both flops reset to 1, so there is no false start after reset.
  - All FSM decisions use `rx_s` only.
- **Counters**
  - Bit-cycle counter: width `$clog2(CLKS_PER_BIT)`.
  - Bit index: 3 bits.
  - `HALF = CLKS_PER_BIT/2`, using integer division.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** counter = 0. When `rx_s == 0`, go to START.
  - **START:** counts to `HALF-1`, then samples `rx_s`.
    - If the sample is 1, the low pulse was a glitch: return to IDLE with no output.
    - If the sample is 0, go to DATA with counter cleared and bit index 0.
  - **DATA:** every `CLKS_PER_BIT` cycles, sample `rx_s` into `shift[bit_index]`. This places the sample at mid-bit and stores the byte LSB first.
    - After bit 7 is sampled, go to STOP.
  - **STOP:** after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - If 1: on the next cycle, `o_data <= shift` and `o_valid` pulses. Return to IDLE at the sample point (mid stop bit), so a back-to-back start edge is caught.
    - If 0: `o_frame_err` pulses, `o_data` is unchanged, and no `o_valid` is produced. Go to BREAK.
  - **BREAK:** wait for `rx_s == 1`, then go to IDLE. A held-low line never produces repeated frames.
- **Overlap rules**
  - `o_valid` and `o_frame_err` are never high in the same cycle.
  - Each frame produces at most one of them.
- **No flow control.** The downstream FIFO drops the byte if it is full. This block does not stall.

## Timing
- **Reset values:** all outputs are 0 (`o_data = 8'h00`), FSM = IDLE, counters = 0, `shift = 0`.
- **Reset mid-frame:** the partial frame is discarded with no pulse. After reset is released, the receiver waits for a fresh falling edge of `rx_s`.
- **Cycle numbering:** let cycle 0 be the first cycle in which `rx_s == 0` is seen in IDLE.
  - Start bit sampled at cycle `HALF`.
  - Data bit n sampled at cycle `HALF + (n+1)*CLKS_PER_BIT`.
  - Stop bit sampled at cycle `HALF + 9*CLKS_PER_BIT`.
  - `o_valid` or `o_frame_err` is high at cycle `HALF + 9*CLKS_PER_BIT + 1`.
- **Latency from `i_rx`:** the synchroniser adds 2 cycles between an `i_rx` edge and the matching `rx_s` edge.
- **`o_busy`:** rises the cycle after IDLE sees `rx_s == 0`. It falls on return to IDLE, i.e. at mid stop bit, or when BREAK exits.
- **Tolerance:** mid-bit sampling tolerates a cumulative baud mismatch of at least ±3% over the 10-bit frame.
- **`o_data` stability:** `o_data` changes only in the cycle `o_valid` is high. This satisfies the FIFO's same-cycle capture.

## Test plan
- **Single frame:** `CLKS_PER_BIT = 16`, send 0xA5 → exactly one `o_valid` pulse at cycle 153 after the `rx_s` fall (8 + 144 + 1), `o_data = 0xA5`, `o_frame_err` never high.
- **Back-to-back frames:** send 0x00, 0xFF, 0x3C with zero idle gap (next start edge right after the stop bit) → three `o_valid` pulses exactly 160 cycles apart, with data 0x00, 0xFF, 0x3C in order.
- **Glitch rejection:** drive `i_rx` low for 5 cycles, then high → no `o_valid` or `o_frame_err`, `o_busy` back to 0 within 10 cycles, and a following 0x5A frame is received correctly.
- **Framing error and break:** send 0x81 with the stop bit low, then hold `i_rx` low for 400 cycles → one `o_frame_err` pulse, no `o_valid`, `o_data` keeps its previous value, FSM stays in BREAK with no further pulses. After the line returns high, a 0x42 frame is received.
- **Reset mid-frame:** assert `i_rst_n = 0` during DATA bit 4 of a frame → all outputs are 0 immediately (asynchronously), no pulse for the aborted frame, and the next complete 0xC3 frame yields `o_valid` with `o_data = 0xC3`.
- **Default baud with skew:** `CLKS_PER_BIT = 868`, drive 0x55 and 0xAA at bit periods of 842 and 894 cycles (±3%) → both bytes received correctly.
